raster_scan: RTL and testbench

Raster-order coordinate stream transmitter for the Sobel datapath. On a start pulse it emits one beat per pixel position (x, y) over a valid/ready handshake, with line and frame markers, and holds each beat until the downstream accepts it. It sits upstream of the line buffers and window logic and is the traffic source for frame-level benches. Its column and row indices are built on the team's up/down/load `counter` block.

---
 rtl/raster_pkg.sv | 13 +
 rtl/counter.sv | 45 ++++
 rtl/raster_scan.sv | 133 +++++++++++++
 tb/tb_raster_scan.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raster_pkg.sv
// Shared types and default geometry for the raster coordinate source.
package raster_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } raster_state_t;

   localparam int RASTER_COLS_DEFAULT = 640;
   localparam int RASTER_ROWS_DEFAULT = 480;

endpackage : raster_pkg

// File: rtl/counter.sv
// Generic up/down counter with synchronous load and optional saturation.
// Load has priority over counting; the count holds when en_i is low.
module counter #(
   parameter int WIDTH_P    = 8,
   parameter bit SATURATE_P = 1'b0
) (
   input  logic               clk_i,
   input  logic               rstn_i,
   input  logic               en_i,
   input  logic               up_i,
   input  logic               load_i,
   input  logic [WIDTH_P-1:0] load_value_i,
   output logic [WIDTH_P-1:0] count_o
);

   logic [WIDTH_P-1:0] count_reg;
   logic [WIDTH_P-1:0] count_next;

   // Next count: load first, then step up or down, optionally clamping at the ends.
   always_comb begin
      count_next = count_reg;
      if (load_i) begin
         count_next = load_value_i;
      end else if (en_i) begin
         if (up_i) begin
            if (!(SATURATE_P && (count_reg == {WIDTH_P{1'b1}})))
               count_next = count_reg + 1'b1;
         end else begin
            if (!(SATURATE_P && (count_reg == {WIDTH_P{1'b0}})))
               count_next = count_reg - 1'b1;
         end
      end
   end

   // Count register, cleared asynchronously by reset.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i)
         count_reg <= '0;
      else
         count_reg <= count_next;
   end

   assign count_o = count_reg;

endmodule : counter

// File: rtl/raster_scan.sv
// Raster-order (x, y) beat source with valid/ready handshake, line/frame
// markers, abort and a one-cycle done pulse after the final beat.
module raster_scan
   import raster_pkg::*;
#(
   parameter int COLS_P    = RASTER_COLS_DEFAULT,
   parameter int ROWS_P    = RASTER_ROWS_DEFAULT,
   parameter int X_WIDTH_P = $clog2(COLS_P),
   parameter int Y_WIDTH_P = $clog2(ROWS_P)
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic                 ready_i,
   output logic                 valid_o,
   output logic [X_WIDTH_P-1:0] x_o,
   output logic [Y_WIDTH_P-1:0] y_o,
   output logic                 sol_o,
   output logic                 eol_o,
   output logic                 sof_o,
   output logic                 eof_o,
   output logic                 busy_o,
   output logic                 done_o
);

   localparam logic [X_WIDTH_P-1:0] X_LAST = X_WIDTH_P'(COLS_P - 1);
   localparam logic [Y_WIDTH_P-1:0] Y_LAST = Y_WIDTH_P'(ROWS_P - 1);

   raster_state_t state_reg;
   raster_state_t state_next;

   logic x_load;
   logic x_inc;
   logic y_load;
   logic y_inc;
   logic in_run;
   logic transfer;
   logic x_at_last;
   logic y_at_last;

   assign in_run    = (state_reg == RUN);
   assign transfer  = in_run && ready_i;
   assign x_at_last = (x_o == X_LAST);
   assign y_at_last = (y_o == Y_LAST);

   // State register; reset drops straight back to IDLE.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Next state and counter controls. Abort beats a same-cycle transfer, and
   // both counters are returned to 0 whenever a frame ends so x/y read 0 outside RUN.
   always_comb begin
      state_next = state_reg;
      x_load     = 1'b0;
      x_inc      = 1'b0;
      y_load     = 1'b0;
      y_inc      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start_i) begin
               state_next = RUN;
               x_load     = 1'b1;
               y_load     = 1'b1;
            end
         end
         RUN: begin
            if (abort_i) begin
               state_next = IDLE;
               x_load     = 1'b1;
               y_load     = 1'b1;
            end else if (transfer) begin
               if (x_at_last) begin
                  x_load = 1'b1;
                  if (y_at_last) begin
                     state_next = DONE;
                     y_load     = 1'b1;
                  end else begin
                     y_inc = 1'b1;
                  end
               end else begin
                  x_inc = 1'b1;
               end
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   counter #(
      .WIDTH_P    (X_WIDTH_P),
      .SATURATE_P (1'b0)
   ) u_x_counter (
      .clk_i        (clk_i),
      .rstn_i       (rstn_i),
      .en_i         (x_inc),
      .up_i         (1'b1),
      .load_i       (x_load),
      .load_value_i ({X_WIDTH_P{1'b0}}),
      .count_o      (x_o)
   );

   counter #(
      .WIDTH_P    (Y_WIDTH_P),
      .SATURATE_P (1'b0)
   ) u_y_counter (
      .clk_i        (clk_i),
      .rstn_i       (rstn_i),
      .en_i         (y_inc),
      .up_i         (1'b1),
      .load_i       (y_load),
      .load_value_i ({Y_WIDTH_P{1'b0}}),
      .count_o      (y_o)
   );

   assign valid_o = in_run;
   assign busy_o  = in_run;
   assign done_o  = (state_reg == DONE);
   assign sol_o   = in_run && (x_o == '0);
   assign eol_o   = in_run && x_at_last;
   assign sof_o   = in_run && (x_o == '0) && (y_o == '0);
   assign eof_o   = in_run && x_at_last && y_at_last;

endmodule : raster_scan

// File: tb/tb_raster_scan.sv
// Self-checking bench for raster_scan on a 4x3 frame with a beat-index model.
`timescale 1ns/1ps
module tb_raster_scan;

   localparam int COLS  = 4;
   localparam int ROWS  = 3;
   localparam int BEATS = COLS * ROWS;

   logic       clk = 1'b0;
   logic       rstn_i = 1'b0;
   logic       start_i = 1'b0;
   logic       abort_i = 1'b0;
   logic       ready_i = 1'b0;
   logic       valid_o;
   logic [1:0] x_o;
   logic [1:0] y_o;
   logic       sol_o, eol_o, sof_o, eof_o, busy_o, done_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   raster_scan #(
      .COLS_P (COLS),
      .ROWS_P (ROWS)
   ) dut (
      .clk_i   (clk),
      .rstn_i  (rstn_i),
      .start_i (start_i),
      .abort_i (abort_i),
      .ready_i (ready_i),
      .valid_o (valid_o),
      .x_o     (x_o),
      .y_o     (y_o),
      .sol_o   (sol_o),
      .eol_o   (eol_o),
      .sof_o   (sof_o),
      .eof_o   (eof_o),
      .busy_o  (busy_o),
      .done_o  (done_o)
   );

   // Observed outputs packed as {valid, x, y, sol, eol, sof, eof, busy, done}.
   logic [10:0] got;
   assign got = {valid_o, x_o, y_o, sol_o, eol_o, sof_o, eof_o, busy_o, done_o};

   // Expected outputs for beat index k of the frame (or an idle/done cycle).
   function automatic logic [10:0] exp_vec(input bit v, input int k, input bit d);
      int xx;
      int yy;
      xx = k % COLS;
      yy = k / COLS;
      if (!v) return {10'b0, d};
      return {1'b1, 2'(xx), 2'(yy), (xx == 0), (xx == COLS - 1),
              (k == 0), (k == BEATS - 1), 1'b1, d};
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_start;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
   endtask

   task automatic test_reset;
      rstn_i = 1'b0;
      repeat (2) step();
      n_checks++;
      if (got !== 11'b0) begin
         n_fail++;
         $display("FAIL reset_held: got %b want %b", got, 11'b0);
      end
      rstn_i = 1'b1;
      step();
      n_checks++;
      if (got !== 11'b0) begin
         n_fail++;
         $display("FAIL reset_released: got %b want %b", got, 11'b0);
      end
      $display("test_reset done");
   endtask

   task automatic test_full_frame;
      ready_i = 1'b1;
      do_start();
      for (int k = 0; k < BEATS; k++) begin
         n_checks++;
         if (got !== exp_vec(1'b1, k, 1'b0)) begin
            n_fail++;
            $display("FAIL full_frame_beat k=%0d: got %b want %b", k, got, exp_vec(1'b1, k, 1'b0));
         end
         step();
      end
      n_checks++;
      if (got !== exp_vec(1'b0, 0, 1'b1)) begin
         n_fail++;
         $display("FAIL full_frame_done: got %b want %b", got, exp_vec(1'b0, 0, 1'b1));
      end
      step();
      n_checks++;
      if (got !== 11'b0) begin
         n_fail++;
         $display("FAIL full_frame_idle: got %b want %b", got, 11'b0);
      end
      $display("test_full_frame done");
   endtask

   task automatic test_backpressure;
      ready_i = 1'b1;
      do_start();
      for (int k = 0; k < BEATS; k++) begin
         if (k == 6) begin
            ready_i = 1'b0;
            for (int h = 0; h < 3; h++) begin
               step();
               n_checks++;
               if (got !== exp_vec(1'b1, 6, 1'b0)) begin
                  n_fail++;
                  $display("FAIL backpressure_hold h=%0d: got %b want %b", h, got, exp_vec(1'b1, 6, 1'b0));
               end
            end
            ready_i = 1'b1;
         end
         n_checks++;
         if (got !== exp_vec(1'b1, k, 1'b0)) begin
            n_fail++;
            $display("FAIL backpressure_beat k=%0d: got %b want %b", k, got, exp_vec(1'b1, k, 1'b0));
         end
         step();
      end
      n_checks++;
      if (got !== exp_vec(1'b0, 0, 1'b1)) begin
         n_fail++;
         $display("FAIL backpressure_done: got %b want %b", got, exp_vec(1'b0, 0, 1'b1));
      end
      step();
      $display("test_backpressure done");
   endtask

   task automatic test_random_ready;
      int k;
      int cycles;
      k = 0;
      cycles = 0;
      ready_i = 1'b0;
      do_start();
      while (k < BEATS && cycles < 500) begin
         n_checks++;
         if (got !== exp_vec(1'b1, k, 1'b0)) begin
            n_fail++;
            $display("FAIL random_beat k=%0d: got %b want %b", k, got, exp_vec(1'b1, k, 1'b0));
         end
         ready_i = 1'($urandom % 2);
         step();
         if (ready_i) k++;
         cycles++;
      end
      ready_i = 1'b0;
      n_checks++;
      if (k != BEATS) begin
         n_fail++;
         $display("FAIL random_timeout: got %0d transfers want %0d", k, BEATS);
      end
      n_checks++;
      if (got !== exp_vec(1'b0, 0, 1'b1)) begin
         n_fail++;
         $display("FAIL random_done: got %b want %b", got, exp_vec(1'b0, 0, 1'b1));
      end
      step();
      n_checks++;
      if (got !== 11'b0) begin
         n_fail++;
         $display("FAIL random_single_done: got %b want %b", got, 11'b0);
      end
      $display("test_random_ready done transfers=%0d cycles=%0d", k, cycles);
   endtask

   task automatic test_abort;
      ready_i = 1'b1;
      do_start();
      for (int k = 0; k < 5; k++) step();
      n_checks++;
      if (got !== exp_vec(1'b1, 5, 1'b0)) begin
         n_fail++;
         $display("FAIL abort_at_beat: got %b want %b", got, exp_vec(1'b1, 5, 1'b0));
      end
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         n_checks++;
         if (got !== 11'b0) begin
            n_fail++;
            $display("FAIL abort_idle c=%0d: got %b want %b", c, got, 11'b0);
         end
         step();
      end
      do_start();
      for (int k = 0; k < BEATS; k++) begin
         n_checks++;
         if (got !== exp_vec(1'b1, k, 1'b0)) begin
            n_fail++;
            $display("FAIL abort_restart k=%0d: got %b want %b", k, got, exp_vec(1'b1, k, 1'b0));
         end
         step();
      end
      step();
      $display("test_abort done");
   endtask

   task automatic test_stray_start;
      ready_i = 1'b1;
      do_start();
      for (int k = 0; k < BEATS; k++) begin
         n_checks++;
         if (got !== exp_vec(1'b1, k, 1'b0)) begin
            n_fail++;
            $display("FAIL stray_beat k=%0d: got %b want %b", k, got, exp_vec(1'b1, k, 1'b0));
         end
         start_i = (k == 3 || k == 8);
         step();
      end
      start_i = 1'b1;
      n_checks++;
      if (got !== exp_vec(1'b0, 0, 1'b1)) begin
         n_fail++;
         $display("FAIL stray_done: got %b want %b", got, exp_vec(1'b0, 0, 1'b1));
      end
      step();
      start_i = 1'b0;
      n_checks++;
      if (got !== 11'b0) begin
         n_fail++;
         $display("FAIL stray_start_in_done: got %b want %b", got, 11'b0);
      end
      step();
      n_checks++;
      if (got !== 11'b0) begin
         n_fail++;
         $display("FAIL stray_still_idle: got %b want %b", got, 11'b0);
      end
      $display("test_stray_start done");
   endtask

   task automatic test_reset_mid_frame;
      ready_i = 1'b1;
      do_start();
      for (int k = 0; k < 3; k++) step();
      n_checks++;
      if (got !== exp_vec(1'b1, 3, 1'b0)) begin
         n_fail++;
         $display("FAIL midreset_at_beat: got %b want %b", got, exp_vec(1'b1, 3, 1'b0));
      end
      #2;
      rstn_i = 1'b0;
      #1;
      n_checks++;
      if (got !== 11'b0) begin
         n_fail++;
         $display("FAIL midreset_immediate: got %b want %b", got, 11'b0);
      end
      #10;
      rstn_i = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         n_checks++;
         if (got !== 11'b0) begin
            n_fail++;
            $display("FAIL midreset_after c=%0d: got %b want %b", c, got, 11'b0);
         end
      end
      do_start();
      n_checks++;
      if (got !== exp_vec(1'b1, 0, 1'b0)) begin
         n_fail++;
         $display("FAIL midreset_restart: got %b want %b", got, exp_vec(1'b1, 0, 1'b0));
      end
      $display("test_reset_mid_frame done");
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_backpressure();
      test_random_ready();
      test_abort();
      test_stray_start();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_raster_scan
